// File: rtl/stream_encoder_pkg.sv
// stream_encoder_pkg: bit-order convention, table field widths and log2 helper shared with stream_decoder.
package stream_encoder_pkg;
  function automatic int log2c(input int n);
    int r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
  localparam bit LSB_FIRST = 1'b1;
  localparam int SYMBOL_BITS = 8;
  localparam int WORD_BITS = 64;
  localparam int CODE_BITS = 9;
  localparam int CODE_WIDTH_BITS = log2c(CODE_BITS + 1);
endpackage

// File: rtl/stream_encoder_output_fifo.sv
// stream_encoder_output_fifo: first-word-fall-through word FIFO with occupancy flags.
module stream_encoder_output_fifo import stream_encoder_pkg::*; #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 8,
  parameter int CW = log2c(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             ready,
  output logic             half_full,
  output logic [CW-1:0]    count
);
  localparam int AW = log2c(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] rd, wr;
  logic do_push, do_pop;
  assign do_pop = pop && ready;
  assign do_push = push && (count != CW'(DEPTH));
  assign ready = count != '0;
  assign half_full = count >= CW'(DEPTH / 2);
  assign q = ready ? mem[rd] : '0;
  always_ff @(posedge clk)
    if (do_push) mem[wr] <= d;
  always_ff @(posedge clk)
    if (rst) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
    end else begin
      wr <= wr + AW'(do_push);
      rd <= rd + AW'(do_pop);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
endmodule

// File: rtl/stream_encoder.sv
// stream_encoder: table-driven prefix-code encoder packing codes LSB-first into words.
module stream_encoder import stream_encoder_pkg::*; #(
  parameter int WIDTH_IN = SYMBOL_BITS,
  parameter int WIDTH_OUT = WORD_BITS,
  parameter int MAX_CODE_LENGTH = CODE_BITS,
  parameter int LOG2_MAX_CODE_LENGTH = log2c(MAX_CODE_LENGTH + 1),
  parameter int FIFO_DEPTH = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            push,
  input  logic [WIDTH_IN-1:0]             d,
  input  logic                            flush,
  output logic                            full,
  output logic                            half_full,
  output logic [WIDTH_OUT-1:0]            q,
  output logic                            ready,
  input  logic                            pop,
  input  logic                            table_push,
  input  logic [WIDTH_IN-1:0]             table_addr,
  input  logic [LOG2_MAX_CODE_LENGTH-1:0] table_code_width,
  input  logic [MAX_CODE_LENGTH-1:0]      table_code
);
  localparam int AW = WIDTH_OUT + MAX_CODE_LENGTH;
  localparam int FW = log2c(AW);
  localparam int CW = log2c(FIFO_DEPTH + 1);
  localparam logic [FW-1:0] WO = FW'(WIDTH_OUT);
  logic [MAX_CODE_LENGTH-1:0] mem_code [2**WIDTH_IN];
  logic [LOG2_MAX_CODE_LENGTH-1:0] mem_width [2**WIDTH_IN];
  logic tw_valid;
  logic [WIDTH_IN-1:0] tw_addr;
  logic [MAX_CODE_LENGTH-1:0] tw_code;
  logic [LOG2_MAX_CODE_LENGTH-1:0] tw_width;
  logic s0_push, s0_flush, s1_push, s1_flush;
  logic [WIDTH_IN-1:0] s0_d;
  logic [MAX_CODE_LENGTH-1:0] s1_code;
  logic [LOG2_MAX_CODE_LENGTH-1:0] s1_width;
  logic [AW-1:0] acc, sum;
  logic [FW-1:0] fill, nf;
  logic wr, over;
  logic [WIDTH_OUT-1:0] wd;
  logic [CW-1:0] count;
  assign full = int'(count) + int'(s0_push | s0_flush) + int'(s1_push | s1_flush) >= FIFO_DEPTH - 1;
  // Stored codes are pre-masked, so acc stays zero above fill and a flush needs no extra masking.
  always_comb begin
    sum = acc | (AW'(s1_code) << fill);
    nf = fill + FW'(s1_width);
    over = nf >= WO;
    wr = s1_push ? over : s1_flush && fill != '0;
    wd = s1_push ? sum[WIDTH_OUT-1:0] : acc[WIDTH_OUT-1:0];
  end
  always_ff @(posedge clk) begin
    if (tw_valid) begin
      mem_code[tw_addr] <= tw_code;
      mem_width[tw_addr] <= tw_width;
    end
    s1_code <= mem_code[s0_d];
    s1_width <= mem_width[s0_d];
  end
  always_ff @(posedge clk) begin
    tw_addr <= table_addr;
    tw_code <= table_code & ~({MAX_CODE_LENGTH{1'b1}} << table_code_width);
    tw_width <= table_code_width;
    s0_d <= d;
    if (rst) begin
      tw_valid <= 1'b0;
      s0_push <= 1'b0;
      s0_flush <= 1'b0;
      s1_push <= 1'b0;
      s1_flush <= 1'b0;
      acc <= '0;
      fill <= '0;
    end else begin
      tw_valid <= table_push;
      s0_push <= push && !full;
      s0_flush <= flush && !push && !full;
      s1_push <= s0_push;
      s1_flush <= s0_flush;
      if (s1_push) begin
        acc <= over ? sum >> WIDTH_OUT : sum;
        fill <= over ? nf - WO : nf;
      end else if (s1_flush) begin
        acc <= '0;
        fill <= '0;
      end
    end
  end
  stream_encoder_output_fifo #(.WIDTH(WIDTH_OUT), .DEPTH(FIFO_DEPTH), .CW(CW)) fifo (
    .clk(clk),
    .rst(rst),
    .push(wr),
    .pop(pop),
    .d(wd),
    .q(q),
    .ready(ready),
    .half_full(half_full),
    .count(count)
  );
endmodule

// File: tb/tb_stream_encoder.sv
// tb_stream_encoder: directed vectors plus randomized traffic against a bit-queue reference model.
module tb_stream_encoder;
  logic clk = 1'b0, rst = 1'b1, push = 1'b0, flush = 1'b0, pop = 1'b0, table_push = 1'b0;
  logic [7:0] d = '0, table_addr = '0;
  logic [3:0] table_code_width = '0;
  logic [8:0] table_code = '0;
  logic full, half_full, ready;
  logic [63:0] q;
  int checks = 0, errors = 0, npop = 0;
  bit bits[$];
  logic [63:0] exp_q[$];
  logic [8:0] mt_code [256];
  logic [3:0] mt_w [256];
  typedef struct {logic [8:0] code; logic [3:0] w; logic has; logic [63:0] word;} vec_t;
  vec_t vec [6];

  always #5 clk = ~clk;

  stream_encoder dut (
    .clk(clk), .rst(rst), .push(push), .d(d), .flush(flush), .full(full), .half_full(half_full),
    .q(q), .ready(ready), .pop(pop), .table_push(table_push), .table_addr(table_addr),
    .table_code_width(table_code_width), .table_code(table_code)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic emit();
    logic [63:0] w = '0;
    for (int i = 0; i < 64 && bits.size() > 0; i++) w[i] = bits.pop_front();
    exp_q.push_back(w);
  endtask

  task automatic m_sym(input logic [7:0] s);
    for (int i = 0; i < int'(mt_w[s]); i++) bits.push_back(mt_code[s][i]);
    while (bits.size() >= 64) emit();
  endtask

  task automatic m_flush();
    if (bits.size() > 0) emit();
  endtask

  task automatic tick(input logic p, input logic [7:0] s, input logic f, input logic pp,
                      input logic tp, input logic [7:0] ta, input logic [3:0] tw, input logic [8:0] tc);
    push = p; d = s; flush = f; pop = pp;
    table_push = tp; table_addr = ta; table_code_width = tw; table_code = tc;
    if (pp && ready) begin
      npop++;
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL pop_extra: got %h expected no word", q);
      end else chk("pop_word", q, exp_q.pop_front());
    end
    if (!full) begin
      if (p) m_sym(s);
      else if (f) m_flush();
    end
    if (tp) begin
      mt_code[ta] = tc;
      mt_w[ta] = tw;
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick(0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic tload(input logic [7:0] a, input logic [3:0] w, input logic [8:0] c);
    tick(0, 0, 0, 0, 1, a, w, c);
  endtask
  task automatic psym(input logic [7:0] s);
    tick(1, s, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic pfl();
    tick(0, 0, 1, 0, 0, 0, 0, 0);
  endtask
  task automatic popw();
    tick(0, 0, 0, 1, 0, 0, 0, 0);
  endtask

  task automatic drain(input string name);
    repeat (20) popw();
    pfl();
    repeat (12) popw();
    chk({name, "_model_empty"}, 64'(exp_q.size()), 64'd0);
    chk({name, "_ready"}, {63'd0, ready}, 64'd0);
  endtask

  initial begin
    vec[0] = '{9'h1FF, 4'd4, 1'b1, 64'h0F};
    vec[1] = '{9'h0AA, 4'd8, 1'b1, 64'hAA};
    vec[2] = '{9'h155, 4'd9, 1'b1, 64'h155};
    vec[3] = '{9'h1FE, 4'd1, 1'b1, 64'h0};
    vec[4] = '{9'h123, 4'd0, 1'b0, 64'h0};
    vec[5] = '{9'h100, 4'd9, 1'b1, 64'h100};
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", {63'd0, ready}, 64'd0);
    chk("reset_q", q, 64'd0);
    chk("reset_full", {63'd0, full}, 64'd0);
    chk("reset_half_full", {63'd0, half_full}, 64'd0);
    rst = 1'b0;
    tload(8'h00, 1, 9'h001);
    tload(8'h01, 2, 9'h002);
    tload(8'h10, 9, 9'h1FF);
    tload(8'h11, 9, 9'h000);
    tload(8'h20, 8, 9'h0A5);
    tload(8'h05, 2, 9'h003);
    idle(3);

    repeat (64) psym(8'h00);
    idle(1);
    chk("pack_ready_early", {63'd0, ready}, 64'd0);
    idle(1);
    chk("pack_ready", {63'd0, ready}, 64'd1);
    chk("pack_word", q, 64'hFFFF_FFFF_FFFF_FFFF);
    popw();
    psym(8'h01);
    pfl();
    idle(3);
    chk("flush_ready", {63'd0, ready}, 64'd1);
    chk("flush_word", q, 64'h2);
    popw();

    repeat (7) psym(8'h10);
    psym(8'h11);
    idle(3);
    chk("straddle_word", q, 64'h7FFF_FFFF_FFFF_FFFF);
    popw();
    pfl();
    idle(3);
    chk("straddle_tail_ready", {63'd0, ready}, 64'd1);
    chk("straddle_tail", q, 64'h0);
    popw();
    chk("straddle_empty", {63'd0, ready}, 64'd0);

    tick(1, 8'h05, 0, 0, 1, 8'h05, 4'd3, 9'h005);
    idle(1);
    psym(8'h05);
    pfl();
    idle(3);
    chk("rdw_word", q, 64'h17);
    popw();

    for (int i = 0; i < 6; i++) begin
      tload(8'h40, vec[i].w, vec[i].code);
      idle(2);
      psym(8'h40);
      pfl();
      idle(3);
      chk($sformatf("vec%0d_ready", i), {63'd0, ready}, {63'd0, vec[i].has});
      if (vec[i].has) chk($sformatf("vec%0d_word", i), q, vec[i].word);
      popw();
    end

    repeat (5) psym(8'h20);
    idle(2);
    psym(8'h20);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    bits.delete();
    exp_q.delete();
    chk("midrst_ready", {63'd0, ready}, 64'd0);
    chk("midrst_q", q, 64'd0);
    chk("midrst_full", {63'd0, full}, 64'd0);
    pfl();
    idle(3);
    chk("midrst_no_word", {63'd0, ready}, 64'd0);

    repeat (100) psym(8'h20);
    chk("bp_full", {63'd0, full}, 64'd1);
    chk("bp_half_full", {63'd0, half_full}, 64'd1);
    chk("bp_held", 64'(exp_q.size()), 64'd7);
    npop = 0;
    tick(1, 8'h20, 0, 1, 0, 0, 0, 0);
    chk("bp_full_release", {63'd0, full}, 64'd0);
    psym(8'h20);
    repeat (20) popw();
    chk("bp_popped", 64'(npop), 64'd7);
    drain("bp");

    for (int i = 0; i < 256; i++) tload(8'(i), 4'($urandom_range(0, 9)), 9'($urandom));
    idle(3);
    for (int i = 0; i < 3000; i++) begin
      if (!ready) chk("rand_q_empty", q, 64'd0);
      tick($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 15) == 0,
           ((i / 300) % 2 == 0) ? $urandom_range(0, 3) != 0 : $urandom_range(0, 5) == 0,
           0, 0, 0, 0);
    end
    drain("rand");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
